// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and default sizes for the CNN datapath blocks.
//   state_t          - writer FSM state (IDLE, RUN, DONE)
//   CNN_DATA_W       - activation width in bits
//   CNN_PACK         - activations per feature-map RAM word
//   CNN_LANE_W       - lane-index width, clog2(CNN_PACK)
//   CNN_ADDR_W       - default RAM word-address width
//   CNN_FRAME_PIXELS - default activations per frame (24x24 map)
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNN_DATA_W       = 8;
    localparam int CNN_PACK         = 4;
    localparam int CNN_LANE_W       = $clog2(CNN_PACK);
    localparam int CNN_ADDR_W       = 12;
    localparam int CNN_FRAME_PIXELS = 576;

endpackage

// File: rtl/fmap_writer.sv
// fmap_writer: sink of the activation stream. Packs PACK activations
// little-endian into one RAM word and writes words to consecutive addresses
// starting at base_addr. A partial last word is flushed with byte enables,
// and done pulses alongside the final write.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         one-cycle pulse, arms a frame (accepted only in IDLE)
//   base_addr     first word address, sampled on an accepted start
//   din, ivalid   activation and its valid strobe (no back-pressure)
//   wr_en         RAM write strobe, one cycle per word
//   wr_addr       RAM word address
//   wr_data       packed word, lane 0 in the LSBs, unfilled lanes 0
//   wr_be         per-lane byte enable
//   busy          high while the frame is running
//   done          one-cycle pulse with the final write
//   err_drop      sticky, an input arrived while not running
module fmap_writer
    import cnn_pkg::*;
#(
    parameter int DATA_W       = CNN_DATA_W,
    parameter int PACK         = CNN_PACK,
    parameter int ADDR_W       = CNN_ADDR_W,
    parameter int FRAME_PIXELS = CNN_FRAME_PIXELS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [DATA_W-1:0]      din,
    input  logic                   ivalid,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W*PACK-1:0] wr_data,
    output logic [PACK-1:0]        wr_be,
    output logic                   busy,
    output logic                   done,
    output logic                   err_drop
);

    localparam int LANE_W    = $clog2(PACK);
    localparam int PIX_W_MIN = $clog2(FRAME_PIXELS + 1);
    // The lane index is the low bits of pix_cnt, so the counter is never
    // narrower than the lane index even for tiny frames.
    localparam int PIX_W     = (PIX_W_MIN > LANE_W) ? PIX_W_MIN : LANE_W;

    state_t                        state;
    logic [PIX_W-1:0]              pix_cnt;
    logic [ADDR_W-1:0]             addr_cnt;
    logic [PACK-1:0][DATA_W-1:0]   lane_buf;
    logic [PACK-1:0]               lane_be;

    logic [LANE_W-1:0]             lane;
    logic                          last_pix;
    logic                          word_done;
    logic [PACK-1:0][DATA_W-1:0]   nxt_buf;
    logic [PACK-1:0]               nxt_be;

    // Buffer and enables as they look once the current byte is merged; a
    // completing byte goes straight from here to the write port.
    always_comb begin
        lane          = pix_cnt[LANE_W-1:0];
        last_pix      = (pix_cnt == PIX_W'(FRAME_PIXELS - 1));
        word_done     = (lane == LANE_W'(PACK - 1)) || last_pix;
        nxt_buf       = lane_buf;
        nxt_buf[lane] = din;
        nxt_be        = lane_be;
        nxt_be[lane]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            addr_cnt <= '0;
            lane_buf <= '0;
            lane_be  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_be    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt <= base_addr;
                        pix_cnt  <= '0;
                        lane_buf <= '0;
                        lane_be  <= '0;
                        // Clear-then-set: a byte arriving with start is
                        // still a drop, so the flag reads 1.
                        err_drop <= ivalid;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else if (ivalid) begin
                        err_drop <= 1'b1;
                    end
                end
                RUN: begin
                    if (ivalid) begin
                        pix_cnt <= pix_cnt + PIX_W'(1);
                        if (word_done) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= addr_cnt;
                            wr_data  <= nxt_buf;
                            wr_be    <= nxt_be;
                            addr_cnt <= addr_cnt + ADDR_W'(1);
                            lane_buf <= '0;
                            lane_be  <= '0;
                            if (last_pix) begin
                                // Final write and done land in the DONE cycle.
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
                            end
                        end else begin
                            lane_buf <= nxt_buf;
                            lane_be  <= nxt_be;
                        end
                    end
                end
                DONE: begin
                    if (ivalid) err_drop <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_writer.sv
// tb_fmap_writer: randomized self-checking bench for fmap_writer.
// Two instances: u_dut_a (8-pixel frames, word aligned) and u_dut_b
// (6-pixel frames, partial last word). A frame-level model turns the list of
// accepted bytes into expected RAM writes (address, data, enables, cycle,
// done) and compares them against writes captured from the DUT.
module tb_fmap_writer;
    import cnn_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int PK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0]    base_addr = '0;
    logic [DW-1:0]    din = '0;
    logic             start_a = 1'b0, ivalid_a = 1'b0;
    logic             start_b = 1'b0, ivalid_b = 1'b0;

    logic             wr_en_a, busy_a, done_a, err_a;
    logic [AW-1:0]    wr_addr_a;
    logic [DW*PK-1:0] wr_data_a;
    logic [PK-1:0]    wr_be_a;
    logic             wr_en_b, busy_b, done_b, err_b;
    logic [AW-1:0]    wr_addr_b;
    logic [DW*PK-1:0] wr_data_b;
    logic [PK-1:0]    wr_be_b;

    fmap_writer #(.DATA_W(DW), .PACK(PK), .ADDR_W(AW), .FRAME_PIXELS(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_addr),
        .din(din), .ivalid(ivalid_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .wr_be(wr_be_a), .busy(busy_a), .done(done_a),
        .err_drop(err_a)
    );

    fmap_writer #(.DATA_W(DW), .PACK(PK), .ADDR_W(AW), .FRAME_PIXELS(6)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_addr),
        .din(din), .ivalid(ivalid_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .wr_be(wr_be_b), .busy(busy_b), .done(done_b),
        .err_drop(err_b)
    );

    typedef struct {
        int               cyc;
        logic [AW-1:0]    addr;
        logic [DW*PK-1:0] data;
        logic [PK-1:0]    be;
        logic             done;
    } wr_t;

    wr_t got_a[$];
    wr_t got_b[$];
    wr_t exp_q[$];

    // Capture every write (and any stray done) away from the active edge.
    always @(negedge clk) begin
        if (wr_en_a || done_a) got_a.push_back('{cyc, wr_addr_a, wr_data_a, wr_be_a, done_a});
        if (wr_en_b || done_b) got_b.push_back('{cyc, wr_addr_b, wr_data_b, wr_be_b, done_b});
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic iv);
        if (sel == 0) begin start_a = st; ivalid_a = iv; end
        else          begin start_b = st; ivalid_b = iv; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame on DUT sel. gap<0 picks 0..2 idle cycles per byte at random.
    task automatic run_frame(input int sel, input logic [AW-1:0] base, input int gap,
                             input bit seq, input logic [DW-1:0] first,
                             input bit mid_start, input bit start_iv, input bit done_drop);
        int               npix;
        int               ng;
        int               k;
        logic [DW*PK-1:0] acc;
        logic [PK-1:0]    be;
        wr_t              g;
        wr_t              e;
        npix = (sel == 0) ? 8 : 6;
        got_a.delete(); got_b.delete(); exp_q.delete();
        tick();
        base_addr = base;
        din = DW'($urandom);
        drive(sel, 1'b1, start_iv);
        tick();
        drive(sel, 1'b0, 1'b0);
        base_addr = AW'($urandom);
        chk("busy_run", (sel == 0) ? busy_a : busy_b, 1);
        chk("err_start", (sel == 0) ? err_a : err_b, start_iv);
        acc = '0;
        be = '0;
        for (int i = 0; i < npix; i++) begin
            ng = (gap < 0) ? $urandom_range(0, 2) : gap;
            for (int j = 0; j < ng; j++) tick();
            din = seq ? DW'(first + DW'(i)) : DW'($urandom);
            drive(sel, mid_start && (i == 2), 1'b1);
            acc[(i % PK) * DW +: DW] = din;
            be[i % PK] = 1'b1;
            if ((i % PK) == PK - 1 || i == npix - 1) begin
                exp_q.push_back('{cyc + 1, AW'(base + AW'(i / PK)), acc, be, (i == npix - 1)});
                acc = '0;
                be = '0;
            end
            tick();
            drive(sel, 1'b0, 1'b0);
        end
        chk("busy_fall", (sel == 0) ? busy_a : busy_b, 0);
        if (done_drop) begin
            drive(sel, 1'b0, 1'b1);
            tick();
            drive(sel, 1'b0, 1'b0);
        end
        repeat (3) tick();
        k = (sel == 0) ? got_a.size() : got_b.size();
        chk("n_writes", k, exp_q.size());
        for (int w = 0; w < exp_q.size() && w < k; w++) begin
            g = (sel == 0) ? got_a[w] : got_b[w];
            e = exp_q[w];
            chk($sformatf("w%0d.cyc", w), g.cyc, e.cyc);
            chk($sformatf("w%0d.addr", w), g.addr, e.addr);
            chk($sformatf("w%0d.data", w), g.data, e.data);
            chk($sformatf("w%0d.be", w), g.be, e.be);
            chk($sformatf("w%0d.done", w), g.done, e.done);
        end
        chk("err_end", (sel == 0) ? err_a : err_b, start_iv || done_drop);
        chk("other_quiet", (sel == 0) ? got_b.size() : got_a.size(), 0);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_wr_en", wr_en_a, 0);
        chk("rst_addr", wr_addr_a, 0);
        chk("rst_data", wr_data_a, 0);
        chk("rst_be", wr_be_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Aligned, partial, gapped.
        run_frame(0, 12'h010, 0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        run_frame(1, 12'h020, 0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        run_frame(0, 12'h010, 2, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);

        // Drop in IDLE: sticky flag, no write; next start clears it.
        got_a.delete();
        drive(0, 1'b0, 1'b1);
        din = 8'h5A;
        tick();
        drive(0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("idle_drop_err", err_a, 1);
        chk("idle_drop_nwr", got_a.size(), 0);
        run_frame(0, 12'h3C0, -1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Address wrap, start-with-byte, drop in DONE.
        run_frame(0, 12'hFFF, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        run_frame(0, 12'h100, -1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        run_frame(1, 12'hFFE, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        for (int f = 0; f < 16; f++)
            run_frame(f % 2, AW'($urandom), -1, 1'b0, 8'h00,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));

        // Reset mid-frame after 3 bytes: nothing written, everything zero.
        got_a.delete();
        tick();
        base_addr = 12'h7A5;
        din = 8'h33;
        drive(0, 1'b1, 1'b1);
        tick();
        drive(0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            din = DW'($urandom);
            drive(0, 1'b0, 1'b1);
            tick();
        end
        drive(0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en_a, 0);
        chk("mid_rst_addr", wr_addr_a, 0);
        chk("mid_rst_data", wr_data_a, 0);
        chk("mid_rst_be", wr_be_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_err", err_a, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("mid_rst_nwr", got_a.size(), 0);

        // Recovery: no leftover lanes from the aborted frame.
        run_frame(0, 12'h040, 0, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fmap_writer.md
Name: fmap_writer

Overview:
- Sink end of the activation stream: consumes signed 8-bit quantized activations with a valid strobe, as produced by the ReLU/requantize stage.
- Packs PACK activations little-endian into one word and writes each word to the feature-map buffer RAM at consecutive addresses from a base address.
- Counts pixels per frame, flushes a partial last word with byte enables, and pulses done so the layer controller can start the next pass.

Parameters:
- DATA_W, 8, activation width in bits.
- PACK, 4, activations per RAM word; power of two, at least 2.
- ADDR_W, 12, RAM word-address width.
- FRAME_PIXELS, 576, activations per frame (24x24 map); at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms a frame.
- base_addr  in  ADDR_W  first word address; sampled on an accepted start.
- din  in  DATA_W  signed activation.
- ivalid  in  1  din valid this cycle.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM word address.
- wr_data  out  DATA_W*PACK  packed word; lane 0 in the LSBs.
- wr_be  out  PACK  per-lane byte enable.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; frame complete.
- err_drop  out  1  sticky; an input was dropped.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, lane buffer 0. Asserting rst_n low mid-frame discards any partial word; no write and no done follow.
- State machine: IDLE, RUN, DONE; all outputs registered.
- IDLE, start=1:
  - Latch base_addr into the address counter.
  - Clear pix_cnt and the lane index; clear err_drop.
  - Go to RUN.
- IDLE, ivalid=1: din discarded; err_drop set.
- RUN, ivalid=1:
  - Store din in lane (pix_cnt mod PACK); increment pix_cnt.
  - If the lane is PACK-1, or pix_cnt was FRAME_PIXELS-1, this byte completes a word.
- Word write on the cycle after a completing byte:
  - wr_en=1 for exactly one cycle; wr_addr = address counter; wr_data = the lane buffer.
  - wr_be has 1s for every lane filled in that word.
  - Unfilled lanes carry 0 in wr_data.
  - The address counter increments after the write and wraps modulo 2^ADDR_W.
  - The lane buffer clears for the next word.
- Throughput and latency: one byte accepted per cycle, with no back-pressure. Full-rate input gives one write every PACK cycles. Latency is 1 cycle from the completing byte to wr_en.
- Frame end:
  - The completing byte at pix_cnt = FRAME_PIXELS-1 moves the state to DONE.
  - In DONE: the final wr_en is issued and done=1 in the same cycle. Next state is IDLE.
- RUN, start=1: ignored; the frame continues.
- DONE, ivalid=1: byte dropped; err_drop set.
- Simultaneous start and ivalid in IDLE: the frame arms; that byte is dropped and err_drop is set. err_drop clears on the start and then sets again, so it reads 1.
- busy = (state == RUN).
- Arithmetic: din is stored bit-exact with no sign handling. The pixel counter is wide enough for FRAME_PIXELS (clog2 of FRAME_PIXELS+1).

Decomposition:
- Shared package cnn_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the localparams for DATA_W, PACK and lane-index width (clog2 of PACK);
  - the default FRAME_PIXELS and ADDR_W.
- No sub-module: the packer and counters are flat in fmap_writer.

Test Plan:
- Aligned frame, FRAME_PIXELS=8, PACK=4, base_addr=0x010, din=1..8 back-to-back:
  - Writes 0x04030201 @0x010 and 0x08070605 @0x011, both with wr_be=4'hF.
  - done pulses with the second write; busy then falls.
- Partial last word, FRAME_PIXELS=6, din=0xA1..0xA6:
  - Second write has wr_data=0x0000A6A5 and wr_be=4'h3; done pulses with it.
- Gapped input (ivalid on every third cycle), 8 pixels:
  - Same data and addresses as the aligned case.
  - Each wr_en comes exactly 1 cycle after the 4th byte of its word.
- Drop and start handling:
  - ivalid in IDLE sets err_drop=1, with no write.
  - start in RUN does not reset pix_cnt.
  - The next accepted start clears err_drop.
- Wrap and reset:
  - base_addr=0xFFF with 8 pixels writes @0xFFF then @0x000.
  - rst_n low after 3 bytes yields no wr_en and no done, and all outputs go to 0.
